// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and FSM state type for the accumulator feeder
package acc_pkg;

    localparam int NUM_ACC_DEF = 256;
    localparam int DATA_W      = 32;
    localparam int ADDR_W_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - feeds vectorEngine beats plus optional residual into the accumulator, returns tiles (ACC_FEEDER_PERF_EN adds perf counters)
module acc_feeder
    import acc_pkg::*;
#(
    parameter int NUM_ACC = NUM_ACC_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cfg_start,
    input  logic [15:0]                 cfg_beats,
    input  logic [15:0]                 cfg_tiles,
    input  logic                        cfg_res_en,
    input  logic [ADDR_W-1:0]           cfg_res_base,
    output logic                        busy,
    output logic                        done,
    output logic                        err_unexp,
    input  logic                        ve_valid,
    output logic                        ve_ready,
    input  logic [NUM_ACC*DATA_W-1:0]   ve_data,
    output logic                        res_rd_en,
    output logic [ADDR_W-1:0]           res_rd_addr,
    input  logic [NUM_ACC*DATA_W-1:0]   res_rd_data,
    output logic                        acc_in_valid,
    output logic                        acc_in_last,
    output logic [NUM_ACC*DATA_W-1:0]   acc_in_data0,
    output logic [NUM_ACC*DATA_W-1:0]   acc_in_data1,
    input  logic                        acc_out_valid,
    input  logic                        acc_out_last,
    input  logic [NUM_ACC*DATA_W-1:0]   acc_out_acc,
    output logic                        tile_valid,
    input  logic                        tile_ready,
    output logic [NUM_ACC*DATA_W-1:0]   tile_data,
    output logic [31:0]                 perf_cycles,
    output logic [31:0]                 perf_stalls
);

    localparam int VW = NUM_ACC * DATA_W;

    feeder_state_e     state_q, state_d;
    logic [15:0]       beats_cfg_q, beats_cfg_d;
    logic [15:0]       tiles_cfg_q, tiles_cfg_d;
    logic              res_en_q, res_en_d;
    logic [ADDR_W-1:0] res_base_q, res_base_d;
    logic [15:0]       beats_left_q, beats_left_d;
    logic [15:0]       tile_idx_q, tile_idx_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              aiv_q, aiv_d;
    logic              ail_q, ail_d;
    logic              res_sel_q, res_sel_d;
    logic [VW-1:0]     tile_data_q, tile_data_d;
    logic [VW-1:0]     data0_q;

    logic xfer;
    logic first_beat;
    logic last_beat;
    logic ret_last;

    assign ve_ready    = (state_q == RUN) && (beats_left_q != 16'd0);
    assign xfer        = ve_ready && ve_valid;
    assign first_beat  = (beats_left_q == beats_cfg_q);
    assign last_beat   = (beats_left_q == 16'd1);
    assign ret_last    = acc_out_valid && acc_out_last;

    // Residual is fetched alongside the first beat so it lands with that beat's drive cycle
    assign res_rd_en   = xfer && res_en_q && first_beat;
    assign res_rd_addr = res_base_q + ADDR_W'(tile_idx_q);

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err_unexp    = err_q;
    assign acc_in_valid = aiv_q;
    assign acc_in_last  = ail_q;
    assign acc_in_data0 = data0_q;
    assign acc_in_data1 = res_sel_q ? res_rd_data : '0;
    assign tile_valid   = (state_q == OUT);
    assign tile_data    = tile_data_q;

    // Next-state and datapath update for the job sequencer
    always_comb begin
        state_d      = state_q;
        beats_cfg_d  = beats_cfg_q;
        tiles_cfg_d  = tiles_cfg_q;
        res_en_d     = res_en_q;
        res_base_d   = res_base_q;
        beats_left_d = beats_left_q;
        tile_idx_d   = tile_idx_q;
        tile_data_d  = tile_data_q;
        done_d       = 1'b0;
        aiv_d        = xfer;
        ail_d        = xfer && last_beat;
        res_sel_d    = res_rd_en;
        err_d        = err_q | (ret_last && (state_q != DRAIN));

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if ((cfg_beats != 16'd0) && (cfg_tiles != 16'd0)) begin
                        state_d      = RUN;
                        beats_cfg_d  = cfg_beats;
                        tiles_cfg_d  = cfg_tiles;
                        res_en_d     = cfg_res_en;
                        res_base_d   = cfg_res_base;
                        beats_left_d = cfg_beats;
                        tile_idx_d   = 16'd0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    beats_left_d = beats_left_q - 16'd1;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ret_last) begin
                    tile_data_d = acc_out_acc;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (tile_ready) begin
                    tile_idx_d = tile_idx_q + 16'd1;
                    if ((tile_idx_q + 16'd1) >= tiles_cfg_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = RUN;
                        beats_left_d = beats_cfg_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, config snapshot, flags and captured tile
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beats_cfg_q  <= 16'd0;
            tiles_cfg_q  <= 16'd0;
            res_en_q     <= 1'b0;
            res_base_q   <= '0;
            beats_left_q <= 16'd0;
            tile_idx_q   <= 16'd0;
            tile_data_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            aiv_q        <= 1'b0;
            ail_q        <= 1'b0;
            res_sel_q    <= 1'b0;
        end else begin
            beats_cfg_q  <= beats_cfg_d;
            tiles_cfg_q  <= tiles_cfg_d;
            res_en_q     <= res_en_d;
            res_base_q   <= res_base_d;
            beats_left_q <= beats_left_d;
            tile_idx_q   <= tile_idx_d;
            tile_data_q  <= tile_data_d;
            err_q        <= err_d;
            done_q       <= done_d;
            aiv_q        <= aiv_d;
            ail_q        <= ail_d;
            res_sel_q    <= res_sel_d;
        end
    end

    // Beat staging register; qualified by acc_in_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            data0_q <= ve_data;
        end
    end

`ifdef ACC_FEEDER_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;
    logic        stall;

    assign stall = ve_ready && !ve_valid;

    // Saturating busy/stall counters, cleared when a job is launched
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_cycles_q <= 32'd0;
            perf_stalls_q <= 32'd0;
        end else if ((state_q == IDLE) && cfg_start) begin
            perf_cycles_q <= 32'd0;
            perf_stalls_q <= 32'd0;
        end else begin
            if (busy && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (stall && (perf_stalls_q != 32'hFFFF_FFFF)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_cycles = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule
